// File: rtl/gpu_pkg.sv
// gpu_pkg: definitions shared across the GPU core datapath blocks.
//   - core_state encoding (IDLE .. DONE)
//   - register write-back source select encoding
//   - indices of the read-only special registers
//   - even_parity(): even-parity bit of a value (zero-extended to 32 bits)
package gpu_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  localparam logic [1:0] MUX_ARITHMETIC = 2'b00;
  localparam logic [1:0] MUX_MEMORY     = 2'b01;
  localparam logic [1:0] MUX_CONSTANT   = 2'b10;

  localparam logic [3:0] REG_GP_LAST   = 4'd12;
  localparam logic [3:0] REG_BLOCK_ID  = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM = 4'd14;
  localparam logic [3:0] REG_THREAD_ID = 4'd15;

  // Bit that makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/thread_registers.sv
// thread_registers: 16-entry per-thread register file feeding the thread
// ALU/LSU. R0-R12 general purpose, R13 block index (tracks block_id),
// R14 block size, R15 thread index. Operands are read in REQUEST and
// results written back in UPDATE.
//
// Ports:
//   clk, reset (async, active-low), enable (low freezes all state)
//   block_id            : current block index, copied into R13 each enabled edge
//   core_state          : core FSM state
//   decoded_rd/rs/rt_address, decoded_reg_write_enable,
//   decoded_reg_input_mux, decoded_immediate : decoded instruction fields
//   alu_out, lsu_out    : write-back data sources
//   rs, rt              : registered operands (hold between REQUESTs)
//   parity_error        : sticky parity fault
//
// Build option: define THREAD_REGISTERS_PARITY_EN to store an even-parity bit
// per register and check it on reads; otherwise parity_error is tied to 0.
module thread_registers
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [7:0]           decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt,
  output logic                 parity_error
);

  localparam logic [DATA_BITS-1:0] BLOCK_DIM_VAL = DATA_BITS'(THREADS_PER_BLOCK);
  localparam logic [DATA_BITS-1:0] THREAD_ID_VAL = DATA_BITS'(THREAD_ID);

  logic [DATA_BITS-1:0] regs [16];

  // Write-back value selection; reserved mux code and special-register
  // destinations suppress the write.
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    if (core_state == CORE_UPDATE && decoded_reg_write_enable &&
        decoded_rd_address <= REG_GP_LAST) begin
      case (decoded_reg_input_mux)
        MUX_ARITHMETIC: begin wr_en = 1'b1; wr_data = alu_out; end
        MUX_MEMORY:     begin wr_en = 1'b1; wr_data = lsu_out; end
        MUX_CONSTANT:   begin wr_en = 1'b1; wr_data = DATA_BITS'(decoded_immediate); end
        default:        begin wr_en = 1'b0; wr_data = '0; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= int'(REG_GP_LAST); i++) regs[i] <= '0;
      regs[REG_BLOCK_ID]  <= '0;
      regs[REG_BLOCK_DIM] <= BLOCK_DIM_VAL;
      regs[REG_THREAD_ID] <= THREAD_ID_VAL;
      rs <= '0;
      rt <= '0;
    end else if (enable) begin
      // R13 follows block_id regardless of core_state; a REQUEST in the same
      // cycle sees the value from before this edge.
      regs[REG_BLOCK_ID] <= DATA_BITS'(block_id);
      if (core_state == CORE_REQUEST) begin
        rs <= regs[decoded_rs_address];
        rt <= regs[decoded_rt_address];
      end
      if (wr_en) regs[decoded_rd_address] <= wr_data;
    end
  end

`ifdef THREAD_REGISTERS_PARITY_EN
  logic par [16];
  logic rd_par_bad;

  assign rd_par_bad =
    (even_parity(32'(regs[decoded_rs_address])) != par[decoded_rs_address]) ||
    (even_parity(32'(regs[decoded_rt_address])) != par[decoded_rt_address]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= int'(REG_GP_LAST); i++) par[i] <= 1'b0;
      par[REG_BLOCK_ID]  <= 1'b0;
      par[REG_BLOCK_DIM] <= even_parity(32'(BLOCK_DIM_VAL));
      par[REG_THREAD_ID] <= even_parity(32'(THREAD_ID_VAL));
      parity_error <= 1'b0;
    end else if (enable) begin
      par[REG_BLOCK_ID] <= even_parity(32'(block_id));
      if (wr_en) par[decoded_rd_address] <= even_parity(32'(wr_data));
      if (core_state == CORE_REQUEST && rd_par_bad) parity_error <= 1'b1;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_thread_registers.sv
// Randomized and directed bench for thread_registers against an array model.
module tb_thread_registers;
  import gpu_pkg::*;

  localparam int TPB = 4;
  localparam int TID = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] block_id = '0;
  logic [2:0] core_state = CORE_IDLE;
  logic [3:0] rd_a = '0, rs_a = '0, rt_a = '0;
  logic       we = 1'b0;
  logic [1:0] mux = '0;
  logic [7:0] imm = '0, alu = '0, lsu = '0;
  logic [7:0] rs, rt;
  logic       parity_error;

  thread_registers #(.THREADS_PER_BLOCK(TPB), .THREAD_ID(TID), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
    .core_state(core_state),
    .decoded_rd_address(rd_a), .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
    .decoded_reg_write_enable(we), .decoded_reg_input_mux(mux),
    .decoded_immediate(imm), .alu_out(alu), .lsu_out(lsu),
    .rs(rs), .rt(rt), .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain register array plus operand latches.
  int m_reg [16];
  int m_rs, m_rt;
  bit m_perr;
  bit m_bad [16];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_reg[i] = 0; m_bad[i] = 0; end
    m_reg[14] = TPB;
    m_reg[15] = TID;
    m_rs = 0; m_rt = 0; m_perr = 0;
  endtask

  // One clock: drive inputs, advance model by the rules, compare after edge.
  task automatic step(input logic e, input logic [2:0] cs, input logic [3:0] d,
                      input logic [3:0] s, input logic [3:0] t, input logic w,
                      input logic [1:0] mx, input logic [7:0] im,
                      input logic [7:0] al, input logic [7:0] ls);
    enable = e; core_state = cs; rd_a = d; rs_a = s; rt_a = t; we = w;
    mux = mx; imm = im; alu = al; lsu = ls;
    @(posedge clk);
    if (e) begin
      if (cs == CORE_REQUEST) begin
        m_rs = m_reg[s];
        m_rt = m_reg[t];
`ifdef THREAD_REGISTERS_PARITY_EN
        if (m_bad[s] || m_bad[t]) m_perr = 1;
`endif
      end
      if (cs == CORE_UPDATE && w && d < 13 && mx != 2'b11) begin
        m_reg[d] = (mx == 2'b00) ? int'(al) : (mx == 2'b01) ? int'(ls) : int'(im);
        m_bad[d] = 0;
      end
      m_reg[13] = block_id;
      m_bad[13] = 0;
    end
    #1;
    check("rs", rs, m_rs);
    check("rt", rt, m_rt);
    check("parity_error", parity_error, m_perr);
  endtask

  task automatic rd_req(input logic [3:0] s, input logic [3:0] t);
    step(1'b1, CORE_REQUEST, 4'd0, s, t, 1'b0, 2'b00, 8'h0, 8'h0, 8'h0);
  endtask

  task automatic wr_upd(input logic [3:0] d, input logic [1:0] mx, input logic [7:0] im,
                        input logic [7:0] al, input logic [7:0] ls);
    step(1'b1, CORE_UPDATE, d, 4'd0, 4'd0, 1'b1, mx, im, al, ls);
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_rs", rs, 0);
    check("reset_rt", rt, 0);
    check("reset_perr", parity_error, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Special registers after reset
    rd_req(4'd14, 4'd15);
    check("blockdim", rs, TPB);
    check("threadid", rt, TID);
    rd_req(4'd0, 4'd0);
    check("r0_zero", rs, 0);

    // Write-back sources
    wr_upd(4'd3, MUX_CONSTANT, 8'h5A, 8'h00, 8'h00);
    rd_req(4'd3, 4'd0);
    check("const_wb", rs, 8'h5A);
    wr_upd(4'd3, MUX_ARITHMETIC, 8'h00, 8'h11, 8'h00);
    rd_req(4'd3, 4'd3);
    check("alu_wb", rs, 8'h11);
    wr_upd(4'd3, MUX_MEMORY, 8'h00, 8'h00, 8'hC3);
    rd_req(4'd3, 4'd3);
    check("lsu_wb", rt, 8'hC3);

    // Dropped writes: special register and reserved mux
    wr_upd(4'd15, MUX_CONSTANT, 8'hFF, 8'h00, 8'h00);
    rd_req(4'd15, 4'd14);
    check("r15_protect", rs, TID);
    wr_upd(4'd5, MUX_CONSTANT, 8'h66, 8'h00, 8'h00);
    wr_upd(4'd5, 2'b11, 8'h99, 8'h99, 8'h99);
    rd_req(4'd5, 4'd5);
    check("mux11_nowrite", rs, 8'h66);

    // Enable low freezes writes and operand latches
    step(1'b0, CORE_UPDATE, 4'd1, 4'd0, 4'd0, 1'b1, MUX_CONSTANT, 8'h07, 8'h0, 8'h0);
    step(1'b0, CORE_REQUEST, 4'd0, 4'd14, 4'd15, 1'b0, 2'b00, 8'h0, 8'h0, 8'h0);
    check("en0_hold_rs", rs, 8'h66);
    rd_req(4'd1, 4'd1);
    check("en0_nowrite", rs, 0);

    // Block index tracking
    block_id = 8'd9;
    step(1'b1, CORE_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'h0, 8'h0, 8'h0);
    rd_req(4'd13, 4'd13);
    check("blockid_r13", rs, 9);

    // Async reset between edges during an UPDATE
    wr_upd(4'd2, MUX_CONSTANT, 8'h3C, 8'h0, 8'h0);
    rd_req(4'd2, 4'd2);
    enable = 1'b1; core_state = CORE_UPDATE; rd_a = 4'd1; we = 1'b1;
    mux = MUX_CONSTANT; imm = 8'h77;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_rs", rs, 0);
    check("async_rt", rt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    block_id = 8'd0;
    rd_req(4'd1, 4'd2);
    check("async_nowrite_r1", rs, 0);
    check("async_clear_r2", rt, 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [2:0] cs;
      int sel;
      sel = $urandom_range(0, 9);
      cs = (sel < 4) ? CORE_REQUEST : (sel < 8) ? CORE_UPDATE : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) block_id = 8'($urandom);
      step(($urandom_range(0, 9) != 0), cs, 4'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

`ifdef THREAD_REGISTERS_PARITY_EN
    // Corrupt one stored bit of R4 and read it
    wr_upd(4'd4, MUX_CONSTANT, 8'h21, 8'h0, 8'h0);
    dut.regs[4] = dut.regs[4] ^ 8'h01;
    m_reg[4] = m_reg[4] ^ 1;
    m_bad[4] = 1;
    rd_req(4'd4, 4'd0);
    check("perr_set", parity_error, 1);
    rd_req(4'd0, 4'd0);
    check("perr_sticky", parity_error, 1);
    reset = 1'b0;
    #1;
    model_reset();
    check("perr_cleared", parity_error, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    block_id = 8'd0;
`else
    check("perr_tied0", parity_error, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
